// File: rtl/jam.sv
// Purpose : exhaustive 8x8 job-assignment solver; walks all 8! permutations, reports min cost and tie count.
// Latency : 10 cycles per permutation (8 fetch + compare + next), 403,200 cycles from reset release to Valid.
// Backpres: none; free-running from reset release, Valid is a single-cycle pulse, results then held until reset.
//
// Ports:
//   CLK        system clock, rising edge
//   RST        asynchronous active-low reset
//   W, J       registered cost-ROM address (worker, job = perm[worker])
//   Cost       cost[W][J] from external combinational ROM, same cycle as W/J
//   MinCost    low 9 bits of the best total, valid from the Valid cycle onward
//   MatchCount number of permutations reaching MinCost, saturating at 15
//   Valid      one-cycle result pulse
module jam (
    input  logic       CLK,
    input  logic       RST,
    output logic [2:0] W,
    output logic [2:0] J,
    input  logic [6:0] Cost,
    output logic [3:0] MatchCount,
    output logic [8:0] MinCost,
    output logic       Valid
);

    typedef enum logic [1:0] {FETCH, CMP, NEXT, DONE} state_t;

    localparam logic [7:0][2:0] PERM_ID = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};

    state_t          state;
    logic [7:0][2:0] perm;
    logic [7:0][2:0] swp;
    logic [7:0][2:0] nperm;
    logic [9:0]      sum;
    logic [9:0]      best;
    logic [3:0]      count;
    logic            found;
    logic [2:0]      i_sel;
    logic [2:0]      k_sel;

    // Lexicographic successor of perm. found=0 means perm is 7,6,...,0 (last one).
    always_comb begin
        found = 1'b0;
        i_sel = 3'd0;
        k_sel = 3'd0;
        // Later hits overwrite earlier ones, so the largest index wins.
        for (int n = 0; n < 7; n++) begin
            if (perm[n] < perm[n+1]) begin
                found = 1'b1;
                i_sel = 3'(n);
            end
        end
        for (int n = 1; n < 8; n++) begin
            if ((3'(n) > i_sel) && (perm[n] > perm[i_sel])) begin
                k_sel = 3'(n);
            end
        end
        swp        = perm;
        swp[i_sel] = perm[k_sel];
        swp[k_sel] = perm[i_sel];
        // Reverse the tail i+1..7: position n takes element i+8-n, which stays in 3 bits for n>i.
        nperm = swp;
        for (int n = 0; n < 8; n++) begin
            if (3'(n) > i_sel) begin
                nperm[n] = swp[i_sel + 3'(8 - n)];
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= FETCH;
            perm       <= PERM_ID;
            W          <= 3'd0;
            J          <= 3'd0;
            sum        <= 10'd0;
            best       <= 10'h3FF;
            count      <= 4'd0;
            MinCost    <= 9'd0;
            MatchCount <= 4'd0;
            Valid      <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    // W==0 starts a fresh sum for this permutation.
                    sum <= ((W == 3'd0) ? 10'd0 : sum) + {3'b000, Cost};
                    if (W == 3'd7) begin
                        W     <= 3'd0;
                        J     <= perm[0];
                        state <= CMP;
                    end else begin
                        W <= W + 3'd1;
                        J <= perm[W + 3'd1];
                    end
                end
                CMP: begin
                    if (sum < best) begin
                        best  <= sum;
                        count <= 4'd1;
                    end else if (sum == best) begin
                        if (count != 4'd15) begin
                            count <= count + 4'd1;
                        end
                    end
                    state <= NEXT;
                end
                NEXT: begin
                    if (!found) begin
                        MinCost    <= best[8:0];
                        MatchCount <= count;
                        Valid      <= 1'b1;
                        state      <= DONE;
                    end else begin
                        perm  <= nperm;
                        J     <= nperm[0];
                        state <= FETCH;
                    end
                end
                DONE: begin
                    Valid <= 1'b0;
                end
                default: state <= DONE;
            endcase
        end
    end

endmodule

// File: tb/tb_jam.sv
// Purpose : self-checking bench for jam; cost ROM model, scoreboard of expected {MinCost, MatchCount}.
// Latency : each run waits up to 410,000 cycles for Valid; expected exactly 403,200.
// Backpres: none; DUT free-runs, bench only observes (samples on the falling edge).
module tb_jam;

    logic       CLK;
    logic       RST;
    logic [2:0] W;
    logic [2:0] J;
    logic [6:0] Cost;
    logic [3:0] MatchCount;
    logic [8:0] MinCost;
    logic       Valid;

    logic [6:0]  rom [8][8];
    logic [12:0] exp_q [$];
    int          n_cmp;
    int          n_bad;

    assign Cost = rom[W][J];

    jam u_jam (
        .CLK        (CLK),
        .RST        (RST),
        .W          (W),
        .J          (J),
        .Cost       (Cost),
        .MatchCount (MatchCount),
        .MinCost    (MinCost),
        .Valid      (Valid)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic load_tbl(input int t);
        for (int w = 0; w < 8; w++) begin
            for (int j = 0; j < 8; j++) begin
                case (t)
                    0:       rom[w][j] = (w == j) ? 7'd0 : 7'd100;
                    1:       rom[w][j] = (j == 7 - w) ? 7'd1 : 7'd50;
                    2:       rom[w][j] = 7'(w + j);
                    default: rom[w][j] = ((w == j) || (w == 0 && j == 1) || (w == 1 && j == 0)) ? 7'd0 : 7'd90;
                endcase
            end
        end
    endtask

    // One full solve; abort_at>0 pulls reset low at that cycle and restarts the run.
    task automatic run(input int abort_at);
        int          cyc;
        int          groups;
        int          bad_grp;
        int          early;
        int          hold_bad;
        int          abort_cyc;
        logic        vld_seen;
        logic [2:0]  jv [8];
        logic [2:0]  pw;
        logic [7:0]  seen;
        logic [12:0] e;
        logic [8:0]  mn;
        logic [3:0]  mc;

        abort_cyc = abort_at;
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        chk("reset_state", int'({W, J, MinCost, MatchCount, Valid}), 0);
        RST = 1'b1;
        cyc = 0; groups = 0; bad_grp = 0; early = 0; vld_seen = 1'b0; pw = 3'd0;
        for (int k = 0; k < 8; k++) jv[k] = 3'd0;

        while (cyc < 410000 && !vld_seen) begin
            @(negedge CLK);
            cyc++;
            if (abort_cyc != 0 && cyc == abort_cyc) begin
                RST = 1'b0;
                #1;
                chk("async_reset_outputs", int'({W, J, MinCost, MatchCount, Valid}), 0);
                repeat (3) @(negedge CLK);
                RST = 1'b1;
                abort_cyc = 0; cyc = 0; groups = 0; pw = 3'd0;
                continue;
            end
            jv[W] = J;
            if (pw == 3'd7 && W == 3'd0) begin
                seen = 8'h00;
                for (int k = 0; k < 8; k++) seen[jv[k]] = 1'b1;
                if (seen != 8'hFF) bad_grp++;
                groups++;
            end else if (W != pw && W != pw + 3'd1) begin
                bad_grp++;
            end
            pw = W;
            if (Valid) vld_seen = 1'b1;
            else if (MinCost != 9'd0 || MatchCount != 4'd0) early++;
        end

        chk("valid_seen", int'(vld_seen), 1);
        chk("latency", cyc, 403200);
        chk("perm_groups", groups, 40320);
        chk("bad_groups", bad_grp, 0);
        chk("early_outputs", early, 0);
        e = exp_q.pop_front();
        chk("min_cost", int'(MinCost), int'(e[12:4]));
        chk("match_count", int'(MatchCount), int'(e[3:0]));

        mn = MinCost; mc = MatchCount; hold_bad = 0;
        repeat (20) begin
            @(negedge CLK);
            if (Valid || MinCost != mn || MatchCount != mc) hold_bad++;
        end
        chk("hold_after_valid", hold_bad, 0);
    endtask

    initial begin
        CLK = 1'b0;
        RST = 1'b0;
        n_cmp = 0;
        n_bad = 0;
        load_tbl(0);

        load_tbl(0); exp_q.push_back({9'd0,  4'd1});  run(0);
        load_tbl(1); exp_q.push_back({9'd8,  4'd1});  run(0);
        load_tbl(2); exp_q.push_back({9'd56, 4'd15}); run(0);
        load_tbl(3); exp_q.push_back({9'd0,  4'd2});  run(0);
        load_tbl(0); exp_q.push_back({9'd0,  4'd1});  run(100000);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
